// File: rtl/fp_add_normalize_if.sv
// Operand and result handshake bundle between Alignment, this stage and its consumer.
interface fp_add_normalize_if #(
    parameter int unsigned EXP_WIDTH = 8,
    parameter int unsigned MAN_WIDTH = 23
);
    logic                         in_valid;
    logic                         in_ready;
    logic                         sign_a;
    logic                         sign_b;
    logic [EXP_WIDTH-1:0]         exponent_out;
    logic [MAN_WIDTH:0]           aligned_mantissa_a;
    logic [MAN_WIDTH:0]           aligned_mantissa_b;
    logic                         out_valid;
    logic                         out_ready;
    logic [EXP_WIDTH+MAN_WIDTH:0] result;
    logic                         overflow;

    // Upstream/downstream side: drives operands and result acceptance
    modport master (
        output in_valid, sign_a, sign_b, exponent_out,
               aligned_mantissa_a, aligned_mantissa_b, out_ready,
        input  in_ready, out_valid, result, overflow
    );

    // Adder stage side
    modport slave (
        input  in_valid, sign_a, sign_b, exponent_out,
               aligned_mantissa_a, aligned_mantissa_b, out_ready,
        output in_ready, out_valid, result, overflow
    );
endinterface

// File: rtl/fp_add_normalize.sv
// FP adder back end: add/subtract aligned magnitudes, normalize, pack single precision.
module fp_add_normalize #(
    parameter int unsigned EXP_WIDTH = 8,
    parameter int unsigned MAN_WIDTH = 23
) (
    input  logic              clk,
    input  logic              rst,
    fp_add_normalize_if.slave bus
);
    localparam int unsigned MW = MAN_WIDTH + 1;  // aligned mantissa incl. hidden bit
    localparam int unsigned SW = MAN_WIDTH + 2;  // sum width incl. carry
    localparam int unsigned RW = 1 + EXP_WIDTH + MAN_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADD,
        S_NORM,
        S_DONE
    } state_t;

    state_t               state;
    state_t               state_nx;

    logic                 sign_a_r;
    logic                 sign_b_r;
    logic [MW-1:0]        man_a_r;
    logic [MW-1:0]        man_b_r;
    logic                 sign_r;
    logic [EXP_WIDTH-1:0] exp_r;
    logic [MW-1:0]        man_r;
    logic                 ovf_r;

    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [RW-1:0]        result_q;
    logic                 overflow_q;

    logic                 in_ready_d;
    logic                 out_valid_d;
    logic [RW-1:0]        result_d;
    logic                 overflow_d;

    logic                 accept;
    logic                 handshake;

    logic [SW-1:0]        add_sum;
    logic                 add_sign;
    logic                 add_carry;
    logic                 add_zero;
    logic [EXP_WIDTH-1:0] exp_inc;

    logic [MW-1:0]        norm_man;
    logic [EXP_WIDTH-1:0] norm_exp;
    logic                 norm_flush;

    assign accept    = bus.in_valid && in_ready_q;
    assign handshake = out_valid_q && bus.out_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.overflow  = overflow_q;

    // Magnitude add or subtract of the captured operands
    always_comb begin
        add_sum  = '0;
        add_sign = 1'b0;
        if (sign_a_r == sign_b_r) begin
            add_sum  = {1'b0, man_a_r} + {1'b0, man_b_r};
            add_sign = sign_a_r;
        end else if (man_a_r >= man_b_r) begin
            add_sum  = {1'b0, man_a_r - man_b_r};
            add_sign = (man_a_r == man_b_r) ? 1'b0 : sign_a_r;
        end else begin
            add_sum  = {1'b0, man_b_r - man_a_r};
            add_sign = sign_b_r;
        end
        add_carry = add_sum[SW-1];
        add_zero  = (add_sum == '0);
        exp_inc   = exp_r + EXP_WIDTH'(1);
    end

    // One-bit left normalization step; underflow flushes to +0
    always_comb begin
        norm_man   = {man_r[MW-2:0], 1'b0};
        norm_exp   = exp_r - EXP_WIDTH'(1);
        norm_flush = (exp_r == '0) || ((norm_exp == '0) && !norm_man[MW-1]);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_ADD;
            S_ADD: begin
                if (add_carry || add_zero || add_sum[MW-1]) state_nx = S_DONE;
                else                                        state_nx = S_NORM;
            end
            S_NORM: if (norm_flush || norm_man[MW-1]) state_nx = S_DONE;
            S_DONE: if (handshake) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Output next values; Result is loaded once on entry to DONE and then held
    always_comb begin
        in_ready_d  = (state_nx == S_IDLE);
        out_valid_d = 1'b0;
        result_d    = result_q;
        overflow_d  = overflow_q;
        if (state == S_DONE) begin
            if (handshake) begin
                out_valid_d = 1'b0;
                overflow_d  = 1'b0;
            end else begin
                out_valid_d = 1'b1;
                if (!out_valid_q) begin
                    result_d   = {sign_r, exp_r, man_r[MAN_WIDTH-1:0]};
                    overflow_d = ovf_r;
                end
            end
        end
    end

    // Output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            overflow_q  <= 1'b0;
        end else begin
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            overflow_q  <= overflow_d;
        end
    end

    // Operand capture, add result and normalization datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_a_r <= 1'b0;
            sign_b_r <= 1'b0;
            man_a_r  <= '0;
            man_b_r  <= '0;
            sign_r   <= 1'b0;
            exp_r    <= '0;
            man_r    <= '0;
            ovf_r    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        sign_a_r <= bus.sign_a;
                        sign_b_r <= bus.sign_b;
                        man_a_r  <= bus.aligned_mantissa_a;
                        man_b_r  <= bus.aligned_mantissa_b;
                        exp_r    <= bus.exponent_out;
                        sign_r   <= 1'b0;
                        man_r    <= '0;
                        ovf_r    <= 1'b0;
                    end
                end
                S_ADD: begin
                    if (add_carry) begin
                        sign_r <= add_sign;
                        exp_r  <= exp_inc;
                        if (exp_inc == '1) begin
                            man_r <= '0;
                            ovf_r <= 1'b1;
                        end else begin
                            man_r <= add_sum[SW-1:1];
                        end
                    end else if (add_zero) begin
                        sign_r <= 1'b0;
                        exp_r  <= '0;
                        man_r  <= '0;
                    end else begin
                        sign_r <= add_sign;
                        man_r  <= add_sum[MW-1:0];
                    end
                end
                S_NORM: begin
                    if (norm_flush) begin
                        sign_r <= 1'b0;
                        exp_r  <= '0;
                        man_r  <= '0;
                    end else begin
                        exp_r <= norm_exp;
                        man_r <= norm_man;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fp_add_normalize.sv
// Scoreboard bench for fp_add_normalize: result, overflow, latency and backpressure.
module tb_fp_add_normalize;
    localparam int unsigned EXP_WIDTH = 8;
    localparam int unsigned MAN_WIDTH = 23;

    typedef struct packed {
        logic [31:0] result;
        logic        ovf;
        logic [7:0]  lat;
    } exp_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    exp_t sb_q[$];

    fp_add_normalize_if #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) bus ();

    fp_add_normalize #(.EXP_WIDTH(EXP_WIDTH), .MAN_WIDTH(MAN_WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Drive one operation, then collect and score its result
    task automatic run_op(input string tag, input logic sa, input logic sb,
                          input logic [7:0] e, input logic [23:0] ma, input logic [23:0] mb,
                          input logic [31:0] want, input logic want_ovf,
                          input int want_lat, input int stall);
        exp_t exp_e;
        exp_t got_e;
        int   n;
        logic [31:0] held;
        @(negedge clk);
        bus.sign_a             = sa;
        bus.sign_b             = sb;
        bus.exponent_out       = e;
        bus.aligned_mantissa_a = ma;
        bus.aligned_mantissa_b = mb;
        bus.out_ready          = (stall == 0);
        bus.in_valid           = 1'b1;
        check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        exp_e.result = want;
        exp_e.ovf    = want_ovf;
        exp_e.lat    = 8'(want_lat);
        sb_q.push_back(exp_e);

        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        got_e = sb_q.pop_front();
        if (!bus.out_valid) begin
            check({tag, "_timeout"}, 32'(bus.out_valid), 32'd1);
            return;
        end
        check({tag, "_latency"}, 32'(n), 32'(got_e.lat));
        check({tag, "_result"}, bus.result, got_e.result);
        check({tag, "_overflow"}, 32'(bus.overflow), 32'(got_e.ovf));
        held = bus.result;

        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_result"}, bus.result, held);
            check({tag, "_hold_ovf"}, 32'(bus.overflow), 32'(got_e.ovf));
            check({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, "_valid_clr"}, 32'(bus.out_valid), 32'd0);
        check({tag, "_ovf_clr"}, 32'(bus.overflow), 32'd0);
        check({tag, "_ready_back"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst                    = 1'b1;
        bus.in_valid           = 1'b0;
        bus.sign_a             = 1'b0;
        bus.sign_b             = 1'b0;
        bus.exponent_out       = '0;
        bus.aligned_mantissa_a = '0;
        bus.aligned_mantissa_b = '0;
        bus.out_ready          = 1'b1;
        #12;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result", bus.result, 32'h0);
        check("rst_overflow", 32'(bus.overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op("one_plus_one", 1'b0, 1'b0, 8'h7F, 24'h800000, 24'h800000, 32'h40000000, 1'b0, 2, 0);
        run_op("sub_norm1",    1'b0, 1'b1, 8'h7F, 24'hC00000, 24'h800000, 32'h3F000000, 1'b0, 3, 0);
        run_op("cancel",       1'b0, 1'b1, 8'h7F, 24'h800000, 24'h800000, 32'h00000000, 1'b0, 2, 0);
        run_op("deep_norm",    1'b0, 1'b1, 8'h7F, 24'h800001, 24'h800000, 32'h34000000, 1'b0, 25, 0);
        run_op("overflow",     1'b0, 1'b0, 8'hFE, 24'hFFFFFF, 24'hFFFFFF, 32'h7F800000, 1'b1, 2, 5);
        run_op("neg_larger_a", 1'b1, 1'b0, 8'h7F, 24'hC00000, 24'h800000, 32'hBF000000, 1'b0, 3, 0);
        run_op("b_larger",     1'b1, 1'b0, 8'h7F, 24'h800000, 24'hC00000, 32'h3F000000, 1'b0, 3, 0);
        run_op("neg_sum",      1'b1, 1'b1, 8'h7F, 24'h800000, 24'h800000, 32'hC0000000, 1'b0, 2, 0);
        run_op("carry_3p0",    1'b0, 1'b0, 8'h7F, 24'hC00000, 24'hC00000, 32'h40400000, 1'b0, 2, 2);
        run_op("underflow",    1'b0, 1'b1, 8'h02, 24'h800001, 24'h800000, 32'h00000000, 1'b0, 4, 0);

        // Asynchronous reset in the middle of a deep normalization
        @(negedge clk);
        bus.sign_a             = 1'b0;
        bus.sign_b             = 1'b1;
        bus.exponent_out       = 8'h7F;
        bus.aligned_mantissa_a = 24'h800001;
        bus.aligned_mantissa_b = 24'h800000;
        bus.out_ready          = 1'b1;
        bus.in_valid           = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("mid_rst_busy", 32'(bus.in_ready), 32'd0);
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_result", bus.result, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_valid", 32'(bus.out_valid), 32'd0);
        run_op("after_rst", 1'b0, 1'b0, 8'h7F, 24'h800000, 24'h800000, 32'h40000000, 1'b0, 2, 0);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fp_add_normalize.md
Name: fp_add_normalize

Overview:
Stage directly downstream of the Alignment stage in the FP adder. Consumes the aligned 24-bit mantissas (hidden bit included), the operand signs and the common exponent (exponentOut). It adds or subtracts the magnitudes, normalizes the result (one right shift on carry-out, or iterative one-bit-per-cycle left shifts), and packs an IEEE-754 single-precision result. Input and output use valid/ready handshakes; one operation is in flight at a time.

Parameters:
EXP_WIDTH, 8, exponent field width
MAN_WIDTH, 23, stored mantissa width; aligned mantissas are MAN_WIDTH+1 bits

Ports:
Clock  input  1  single clock, rising edge
Reset  input  1  asynchronous, active-high reset
inValid  input  1  upstream operand set valid
inReady  output  1  block can accept an operand set
signA  input  1  sign of operand A
signB  input  1  sign of operand B
exponentOut  input  EXP_WIDTH  common exponent from Alignment
alignedMantissaA  input  MAN_WIDTH+1  aligned A mantissa
alignedMantissaB  input  MAN_WIDTH+1  aligned B mantissa
outValid  output  1  Result valid
outReady  input  1  downstream accepts Result
Result  output  1+EXP_WIDTH+MAN_WIDTH  packed {sign, exponent, mantissa}
overflow  output  1  Result saturated to infinity

Behaviour:
- Reset (async, active-high): state IDLE; outValid=0, Result=0, overflow=0, inReady=1; all internal registers are cleared. Reset mid-operation discards the operation; no output is produced.
- FSM states: IDLE, ADD, NORM, DONE.
- IDLE: inReady=1. When inValid&&inReady at an edge, capture signs, exponentOut and both mantissas, then go to ADD. inReady=0 in every other state.
- ADD (one cycle):
  - Same signs: sum = A+B, MAN_WIDTH+2 bits wide; result sign = signA.
  - Different signs: subtract smaller from larger by unsigned compare of the aligned mantissas; sign = sign of the larger; A==B gives +0.
  - Carry (sum bit 24): shift right 1 (LSB truncated), exponent+1. If the new exponent == all-ones, Result = {sign, 8'hFF, 0} and overflow=1.
  - Zero result, carry, or bit 23 already set: go to DONE. Otherwise go to NORM.
- NORM: each cycle, shift mantissa left by 1 and decrement exponent.
  - Leave for DONE when bit 23 becomes 1.
  - If the exponent reaches 0 before bit 23 is set, flush to +0 (Result=0) and go to DONE.
  - Maximum 23 NORM cycles.
- DONE: outValid=1. Result = {sign, exponent, mantissa[22:0]}, held stable while outReady=0. On outValid&&outReady at an edge: outValid=0, overflow=0, go to IDLE.
- Rounding: truncation only. No NaN, infinity or subnormal inputs (Alignment always supplies the hidden 1).
- Latency, counted from the accept edge T: outValid rises after edge T+2 with no normalization, or after edge T+2+k for k left shifts.
- Throughput: one operation per (latency + 1 handshake) cycles.
- inValid is ignored outside IDLE; inputs are sampled only at the accept edge.

Test Plan:
1. 1.0+1.0: exponentOut=8'h7F, mantissas 24'h800000/24'h800000, signs 0/0 -> Result 32'h40000000, overflow=0, outValid exactly 2 cycles after accept.
2. 1.5-1.0: 24'hC00000 (signA=0) and 24'h800000 (signB=1), exponentOut=8'h7F -> one NORM cycle, Result 32'h3F000000, outValid 3 cycles after accept.
3. Exact cancellation: both mantissas 24'h800000, signs 0/1, exponentOut=8'h7F -> Result 32'h00000000, outValid 2 cycles after accept.
4. Deep normalization: 24'h800001 (sign 0) minus 24'h800000 (sign 1), exponentOut=8'h7F -> 23 NORM cycles, Result 32'h34000000, latency 25.
5. Overflow and backpressure: exponentOut=8'hFE, both mantissas 24'hFFFFFF, signs 0/0, outReady held 0 for 5 cycles -> Result 32'h7F800000 and overflow=1 held stable, inReady=0 throughout; both clear one edge after outReady=1.
6. Reset mid-NORM: assert Reset during case 4 at NORM cycle 10 -> outValid=0 immediately (asynchronous); after deassert inReady=1; the next operation (case 1) still returns 32'h40000000.
